// File: rtl/cpu_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute, drives every datapath strobe,
// and owns the data-bus handshake with a wait-state timeout that halts the core.
module cpu_control_unit #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [31:0] i_Instruction,
   input  logic        i_ALUZero,
   input  logic        i_Bus_Ready,
   output logic        o_PCWrite,
   output logic        o_IRegWR,
   output logic        o_REGWriteEn,
   output logic [1:0]  o_REGWriteSrc,
   output logic [3:0]  o_ALUOpCode,
   output logic [1:0]  o_ALUSrcASel,
   output logic [1:0]  o_ALUSrcBSel,
   output logic        o_Bus_RE,
   output logic        o_Bus_WE,
   output logic        o_Halted,
   output logic [1:0]  o_Fault
);

   localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_SLL   = 4'h2;
   localparam logic [3:0] ALU_SLT   = 4'h3;
   localparam logic [3:0] ALU_SLTU  = 4'h4;
   localparam logic [3:0] ALU_XOR   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SRA   = 4'h7;
   localparam logic [3:0] ALU_OR    = 4'h8;
   localparam logic [3:0] ALU_AND   = 4'h9;
   localparam logic [3:0] ALU_PASSB = 4'hA;

   localparam logic [1:0] FLT_ILLEGAL = 2'd1;
   localparam logic [1:0] FLT_TIMEOUT = 2'd2;
   localparam logic [1:0] FLT_SYSTEM  = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH0, S_FETCH1, S_DECODE, S_EXEC, S_JUMP,
      S_BRANCH, S_BR_TAKE, S_LOAD, S_STORE, S_HALT
   } state_t;

   state_t          r_State, w_NextState;
   logic [1:0]      r_Fault, w_NextFault;
   logic [CW-1:0]   r_WaitCnt;

   logic [6:0] w_Opcode;
   logic [2:0] w_Funct3;
   logic [6:0] w_Funct7;
   logic       w_RdNZ;
   logic       w_OpLegal;
   logic       w_BrLegal;
   logic       w_MemLegal;
   logic       w_AluAlt;
   logic [3:0] w_AluFn;
   logic [3:0] w_BrAluFn;
   logic       w_BrTaken;
   logic       w_TimeoutHit;
   logic       w_unused;

   assign w_Opcode   = i_Instruction[6:0];
   assign w_Funct3   = i_Instruction[14:12];
   assign w_Funct7   = i_Instruction[31:25];
   assign w_RdNZ     = (i_Instruction[11:7] != 5'd0);
   assign w_unused   = ^i_Instruction[24:15];

   assign w_OpLegal  = (w_Funct7 == 7'h00) ||
                       ((w_Funct7 == 7'h20) && ((w_Funct3 == 3'b000) || (w_Funct3 == 3'b101)));
   assign w_BrLegal  = (w_Funct3[2:1] != 2'b01);
   assign w_MemLegal = (w_Funct3 == 3'b010);

   // OP-IMM only honours bit 30 for SRAI; ADDI must never become a subtract.
   assign w_AluAlt   = i_Instruction[30] && ((w_Opcode == OPC_OP) || (w_Funct3 == 3'b101));

   // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero.
   assign w_BrTaken  = i_ALUZero ^ (w_Funct3[0] ^ w_Funct3[2]);

   assign w_TimeoutHit = (BUS_TIMEOUT != 0) && (r_WaitCnt == CW'(BUS_TIMEOUT - 1));

   assign o_Fault = r_Fault;

   always_comb begin
      w_AluFn = ALU_ADD;
      case (w_Funct3)
         3'b000:  w_AluFn = w_AluAlt ? ALU_SUB : ALU_ADD;
         3'b001:  w_AluFn = ALU_SLL;
         3'b010:  w_AluFn = ALU_SLT;
         3'b011:  w_AluFn = ALU_SLTU;
         3'b100:  w_AluFn = ALU_XOR;
         3'b101:  w_AluFn = w_AluAlt ? ALU_SRA : ALU_SRL;
         3'b110:  w_AluFn = ALU_OR;
         default: w_AluFn = ALU_AND;
      endcase
   end

   always_comb begin
      w_BrAluFn = ALU_SUB;
      case (w_Funct3[2:1])
         2'b10:   w_BrAluFn = ALU_SLT;
         2'b11:   w_BrAluFn = ALU_SLTU;
         default: w_BrAluFn = ALU_SUB;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_State   <= S_FETCH0;
         r_Fault   <= '0;
         r_WaitCnt <= '0;
      end else begin
         r_State <= w_NextState;
         r_Fault <= w_NextFault;
         if (r_State == S_DECODE)
            r_WaitCnt <= '0;
         else if (((r_State == S_LOAD) || (r_State == S_STORE)) && !i_Bus_Ready)
            r_WaitCnt <= r_WaitCnt + CW'(1);
      end
   end

   always_comb begin
      w_NextState   = r_State;
      w_NextFault   = r_Fault;
      o_PCWrite     = 1'b0;
      o_IRegWR      = 1'b0;
      o_REGWriteEn  = 1'b0;
      o_REGWriteSrc = 2'd0;
      o_ALUOpCode   = ALU_ADD;
      o_ALUSrcASel  = 2'd0;
      o_ALUSrcBSel  = 2'd0;
      o_Bus_RE      = 1'b0;
      o_Bus_WE      = 1'b0;
      o_Halted      = 1'b0;
      case (r_State)
         S_FETCH0: w_NextState = S_FETCH1;
         S_FETCH1: begin
            o_IRegWR     = 1'b1;
            o_PCWrite    = 1'b1;
            o_ALUSrcASel = 2'd1;
            o_ALUSrcBSel = 2'd1;
            w_NextState  = S_DECODE;
         end
         S_DECODE: begin
            w_NextState = S_HALT;
            w_NextFault = FLT_ILLEGAL;
            case (w_Opcode)
               OPC_OP: if (w_OpLegal) begin
                  w_NextState = S_EXEC;
                  w_NextFault = r_Fault;
               end
               OPC_OPIMM, OPC_LUI, OPC_AUIPC: begin
                  w_NextState = S_EXEC;
                  w_NextFault = r_Fault;
               end
               OPC_JAL, OPC_JALR: begin
                  w_NextState = S_JUMP;
                  w_NextFault = r_Fault;
               end
               OPC_BRANCH: if (w_BrLegal) begin
                  w_NextState = S_BRANCH;
                  w_NextFault = r_Fault;
               end
               OPC_LOAD: if (w_MemLegal) begin
                  w_NextState = S_LOAD;
                  w_NextFault = r_Fault;
               end
               OPC_STORE: if (w_MemLegal) begin
                  w_NextState = S_STORE;
                  w_NextFault = r_Fault;
               end
               OPC_FENCE: begin
                  w_NextState = S_FETCH0;
                  w_NextFault = r_Fault;
               end
               OPC_SYSTEM: w_NextFault = FLT_SYSTEM;
               default: ;
            endcase
         end
         S_EXEC: begin
            o_REGWriteSrc = 2'd2;
            o_REGWriteEn  = w_RdNZ;
            w_NextState   = S_FETCH0;
            case (w_Opcode)
               OPC_OP: begin
                  o_ALUSrcASel = 2'd2;
                  o_ALUOpCode  = w_AluFn;
               end
               OPC_OPIMM: begin
                  o_ALUSrcASel = 2'd2;
                  o_ALUSrcBSel = 2'd2;
                  o_ALUOpCode  = w_AluFn;
               end
               OPC_LUI: begin
                  o_ALUSrcBSel = 2'd2;
                  o_ALUOpCode  = ALU_PASSB;
               end
               default: o_ALUSrcBSel = 2'd2;
            endcase
         end
         S_JUMP: begin
            o_REGWriteEn = w_RdNZ;
            o_PCWrite    = 1'b1;
            o_ALUSrcASel = (w_Opcode == OPC_JALR) ? 2'd2 : 2'd0;
            o_ALUSrcBSel = 2'd2;
            w_NextState  = S_FETCH0;
         end
         S_BRANCH: begin
            o_ALUSrcASel = 2'd2;
            o_ALUOpCode  = w_BrAluFn;
            w_NextState  = w_BrTaken ? S_BR_TAKE : S_FETCH0;
         end
         S_BR_TAKE: begin
            o_PCWrite    = 1'b1;
            o_ALUSrcBSel = 2'd2;
            w_NextState  = S_FETCH0;
         end
         S_LOAD: begin
            o_ALUSrcASel  = 2'd2;
            o_ALUSrcBSel  = 2'd2;
            o_Bus_RE      = 1'b1;
            o_REGWriteSrc = 2'd1;
            if (i_Bus_Ready) begin
               o_REGWriteEn = w_RdNZ;
               w_NextState  = S_FETCH0;
            end else if (w_TimeoutHit) begin
               w_NextState = S_HALT;
               w_NextFault = FLT_TIMEOUT;
            end
         end
         S_STORE: begin
            o_ALUSrcASel = 2'd2;
            o_ALUSrcBSel = 2'd2;
            o_Bus_WE     = 1'b1;
            if (i_Bus_Ready) begin
               w_NextState = S_FETCH0;
            end else if (w_TimeoutHit) begin
               w_NextState = S_HALT;
               w_NextFault = FLT_TIMEOUT;
            end
         end
         S_HALT: o_Halted = 1'b1;
         default: w_NextState = S_FETCH0;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: per-instruction expected output sequences built from the
// instruction-set rules, compared every cycle, plus hand-computed directed checks.
module tb_cpu_control_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        i_Rst;
   logic [31:0] i_Instruction;
   logic        i_ALUZero;
   logic        i_Bus_Ready;
   logic        o_PCWrite, o_IRegWR, o_REGWriteEn, o_Bus_RE, o_Bus_WE, o_Halted;
   logic [1:0]  o_REGWriteSrc, o_ALUSrcASel, o_ALUSrcBSel, o_Fault;
   logic [3:0]  o_ALUOpCode;

   always #5 clk = ~clk;

   cpu_control_unit #(.BUS_TIMEOUT(TMO)) dut (
      .i_Clk(clk), .i_Rst(i_Rst), .i_Instruction(i_Instruction), .i_ALUZero(i_ALUZero),
      .i_Bus_Ready(i_Bus_Ready), .o_PCWrite(o_PCWrite), .o_IRegWR(o_IRegWR),
      .o_REGWriteEn(o_REGWriteEn), .o_REGWriteSrc(o_REGWriteSrc), .o_ALUOpCode(o_ALUOpCode),
      .o_ALUSrcASel(o_ALUSrcASel), .o_ALUSrcBSel(o_ALUSrcBSel), .o_Bus_RE(o_Bus_RE),
      .o_Bus_WE(o_Bus_WE), .o_Halted(o_Halted), .o_Fault(o_Fault)
   );

   typedef struct packed {
      logic       pcw, irw, rwe;
      logic [1:0] src;
      logic [3:0] op;
      logic [1:0] a, b;
      logic       re, we, halted;
      logic [1:0] fault;
   } vec_t;

   vec_t exp_q[$];
   vec_t act_q[$];
   logic rdy_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic pcw, irw, rwe, input logic [1:0] src,
                               input logic [3:0] op, input logic [1:0] a, b,
                               input logic re, we, h, input logic [1:0] f);
      vec_t v;
      v = '{pcw, irw, rwe, src, op, a, b, re, we, h, f};
      return v;
   endfunction

   function automatic vec_t sample();
      return mk(o_PCWrite, o_IRegWR, o_REGWriteEn, o_REGWriteSrc, o_ALUOpCode,
                o_ALUSrcASel, o_ALUSrcBSel, o_Bus_RE, o_Bus_WE, o_Halted, o_Fault);
   endfunction

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    return alt ? 4'h1 : 4'h0;
         3'd1:    return 4'h2;
         3'd2:    return 4'h3;
         3'd3:    return 4'h4;
         3'd4:    return 4'h5;
         3'd5:    return alt ? 4'h7 : 4'h6;
         3'd6:    return 4'h8;
         default: return 4'h9;
      endcase
   endfunction

   task automatic push(input vec_t v, input logic r);
      exp_q.push_back(v);
      rdy_q.push_back(r);
   endtask

   // Reference: the full cycle-by-cycle output sequence of one instruction.
   task automatic model(input logic [31:0] ins, input int waits, input logic z);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       wr, ld, taken;
      int         fault;
      vec_t       v;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      wr  = (ins[11:7] != 0);
      fault = 0;
      push('0, 1'($urandom_range(0, 1)));
      push(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
      push('0, 1'($urandom_range(0, 1)));
      case (opc)
         7'h13, 7'h33, 7'h37, 7'h17: begin
            if (opc == 7'h33 && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))))
               fault = 1;
            else if (opc == 7'h37)
               push(mk(0, 0, wr, 2, 4'hA, 0, 2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
            else if (opc == 7'h17)
               push(mk(0, 0, wr, 2, 4'h0, 0, 2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
            else
               push(mk(0, 0, wr, 2, alu_ref(f3, ins[30] && (opc == 7'h33 || f3 == 5)), 2,
                       (opc == 7'h33) ? 2'd0 : 2'd2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
         end
         7'h6F, 7'h67:
            push(mk(1, 0, wr, 0, 0, (opc == 7'h6F) ? 2'd0 : 2'd2, 2, 0, 0, 0, 0),
                 1'($urandom_range(0, 1)));
         7'h63: begin
            if (f3 == 2 || f3 == 3) fault = 1;
            else begin
               push(mk(0, 0, 0, 0, (f3 < 4) ? 4'h1 : ((f3 < 6) ? 4'h3 : 4'h4), 2, 0, 0, 0, 0, 0),
                    1'($urandom_range(0, 1)));
               taken = (f3 == 0 || f3 == 5 || f3 == 7) ? z : !z;
               if (taken) push(mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
            end
         end
         7'h03, 7'h23: begin
            if (f3 != 2) fault = 1;
            else begin
               ld = (opc == 7'h03);
               for (int k = 0; k <= waits; k++) begin
                  v = mk(0, 0, 0, ld ? 2'd1 : 2'd0, 0, 2, 2, ld, !ld, 0, 0);
                  if (k == waits) begin
                     v.rwe = ld && wr;
                     push(v, 1'b1);
                  end else begin
                     push(v, 1'b0);
                     if (k + 1 == TMO) begin
                        fault = 2;
                        break;
                     end
                  end
               end
            end
         end
         7'h0F: ;
         7'h73: fault = 3;
         default: fault = 1;
      endcase
      if (fault != 0)
         repeat (3) push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'(fault)), 1'($urandom_range(0, 1)));
   endtask

   task automatic check(input string name, input vec_t got, input vec_t want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic do_reset(input int cycles);
      i_Rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 i_Rst = 1'b0;
   endtask

   // Runs one instruction from FETCH0; compares the DUT with the model every cycle.
   task automatic run(input logic [31:0] ins, input int waits, input logic z, input int abort_at);
      exp_q.delete(); rdy_q.delete(); act_q.delete();
      model(ins, waits, z);
      i_Instruction = ins;
      i_ALUZero     = z;
      foreach (exp_q[i]) begin
         if (i == abort_at) begin
            i_Bus_Ready = 1'b0;
            do_reset(1);
            return;
         end
         i_Bus_Ready = rdy_q[i];
         @(negedge clk);
         act_q.push_back(sample());
         check($sformatf("cycle %0d of %08h", i, ins), act_q[act_q.size() - 1], exp_q[i]);
         @(posedge clk);
         #1;
      end
      if (exp_q[exp_q.size() - 1].halted) do_reset(1);
   endtask

   initial begin
      logic [31:0] ins;
      int          kind;
      i_Instruction = '0;
      i_ALUZero     = 1'b0;
      i_Bus_Ready   = 1'b0;
      @(negedge clk);
      do_reset(2);

      run(32'h00500093, 0, 0, -1);               // ADDI x1,x0,5
      check("reset_fetch0", act_q[0], '0);
      check("addi_fetch1", act_q[1], mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      check("addi_exec", act_q[3], mk(0, 0, 1, 2, 0, 2, 2, 0, 0, 0, 0));
      check_int("addi_cpi", act_q.size(), 4);

      run(32'h00000463, 0, 1, -1);               // BEQ taken
      check_int("beq_cpi", act_q.size(), 5);
      check("beq_take", act_q[4], mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));

      run(32'h00001463, 0, 1, -1);               // BNE not taken
      check_int("bne_cpi", act_q.size(), 4);
      check("bne_branch", act_q[3], mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));

      run(32'h0000A283, 3, 0, -1);               // LW x5 with 3 wait states
      check_int("lw_cpi", act_q.size(), 7);
      for (int i = 3; i < 6; i++)
         check($sformatf("lw_wait%0d", i), act_q[i], mk(0, 0, 0, 1, 0, 2, 2, 1, 0, 0, 0));
      check("lw_ready", act_q[6], mk(0, 0, 1, 1, 0, 2, 2, 1, 0, 0, 0));

      run(32'h0050A023, 100, 0, -1);             // SW, bus never ready
      check_int("sw_tmo_len", act_q.size(), 10);
      for (int i = 3; i < 7; i++)
         check($sformatf("sw_we%0d", i), act_q[i], mk(0, 0, 0, 0, 0, 2, 2, 0, 1, 0, 0));
      check("sw_tmo_halt", act_q[7], mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));

      run(32'h0000006F, 0, 0, -1);               // JAL x0
      check("jal_x0", act_q[3], mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));

      run(32'h0000007F, 0, 0, -1);
      check("illegal_halt", act_q[3], mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

      run(32'h00000073, 0, 0, -1);               // ECALL
      check("ecall_halt", act_q[3], mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));

      run(32'h0000A283, 100, 0, 5);              // reset during LW wait
      run(32'h00500093, 0, 0, -1);
      check("post_reset_f0", act_q[0], '0);
      check_int("post_reset_cpi", act_q.size(), 4);

      for (int n = 0; n < 400; n++) begin
         ins  = $urandom();
         kind = $urandom_range(0, 11);
         case (kind)
            0: ins[6:0] = 7'h13;
            1: begin
               ins[6:0] = 7'h33;
               if ($urandom_range(0, 4) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
            end
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            4: ins[6:0] = 7'h6F;
            5: ins[6:0] = 7'h67;
            6, 7: ins[6:0] = 7'h63;
            8, 9: begin
               ins[6:0] = (kind == 8) ? 7'h03 : 7'h23;
               if ($urandom_range(0, 4) != 0) ins[14:12] = 3'b010;
            end
            10: ins[6:0] = 7'h0F;
            default: if ($urandom_range(0, 1) != 0) ins[6:0] = 7'h73;
         endcase
         if ($urandom_range(0, 4) == 0) ins[11:7] = 5'd0;
         run(ins, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
